bus_timer: RTL and testbench
============================

BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 The parameter BASE_ADDR SHALL have default 32'hFFFF_F020 and SHALL be the byte address of the register window, which is 32 bytes and aligned to 32 bytes.
REQ-002 cpu_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 cpu_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Bus_addr  input  32  SHALL be the byte address driven by the CPU bus initiator.
REQ-005 Bus_wen  input  1  SHALL be the write strobe; a write commits on the rising edge where Bus_wen=1 and the address hits.
REQ-006 Bus_wdata  input  32  SHALL be the write data.
REQ-007 Bus_rdata  output  32  SHALL be the read data: combinational from Bus_addr in the same cycle, zero wait states.
REQ-008 timer_irq  output  1  SHALL be the level interrupt, equal to STATUS.expired AND CTRL.irq_en.

Function
REQ-009 An address SHALL hit when Bus_addr[31:5]==BASE_ADDR[31:5]; the register SHALL be selected by Bus_addr[4:2], and Bus_addr[1:0] SHALL be ignored.
REQ-010 The register map SHALL be: 0x00 CTRL (bit0 en, bit1 auto_reload, bit2 irq_en), 0x04 PRESCALE[15:0], 0x08 RELOAD[31:0], 0x0C COUNT[31:0], 0x10 STATUS (bit0 expired).
REQ-011 Offsets 0x14-0x1C and all misses SHALL read 0 and ignore writes; unused register bits SHALL read 0.
REQ-012 Prescaler: when en=1, an internal 16-bit pcnt SHALL increment each cycle; when pcnt==PRESCALE it SHALL wrap to 0 and assert a one-cycle tick. The tick period SHALL therefore be PRESCALE+1 cycles.
REQ-013 On a tick with COUNT!=0, COUNT SHALL decrement by 1.
REQ-014 On a tick with COUNT==0, expired SHALL be set to 1. If auto_reload=1, COUNT SHALL load RELOAD and en SHALL stay 1. If auto_reload=0, COUNT SHALL stay 0 and en SHALL clear to 0.
REQ-015 With en=0, pcnt and COUNT SHALL hold and no tick SHALL occur.
REQ-016 A write setting en from 0 to 1 SHALL clear pcnt to 0 in that same edge.
REQ-017 A write to COUNT in the same cycle as a tick SHALL take precedence; the written value SHALL be loaded and there SHALL be no decrement and no reload.
REQ-018 A write to CTRL in the same cycle as an auto-clear of en (REQ-014) SHALL take precedence with the written value.
REQ-019 Writing 1 to STATUS bit0 SHALL clear expired, and writing 0 SHALL have no effect. If a clear and an expiry happen in the same cycle, expired SHALL be 1 (set wins).
REQ-020 A write to PRESCALE SHALL take effect for the next comparison. If the new PRESCALE is less than the current pcnt, pcnt SHALL count up and wrap through 16'hFFFF to 0 with no tick, then continue normally.
REQ-021 A read of COUNT SHALL return the registered value before any update at the current edge.

Reset
REQ-022 When cpu_rst=1 at a rising edge, CTRL, PRESCALE, RELOAD, COUNT, STATUS and pcnt SHALL all become 0.
REQ-023 During and immediately after reset, timer_irq SHALL be 0, and Bus_rdata SHALL be 0 for every hit address.
REQ-024 Reset asserted mid-countdown SHALL abort the countdown with no expiry; cpu_rst SHALL take precedence over a simultaneous bus write.

Verification
REQ-025 Basic countdown: write PRESCALE=3, COUNT=2, CTRL=0x5 -> ticks every 4 cycles; COUNT reads 1 then 0; expired=1 and timer_irq=1 on the 3rd tick (12 cycles after the CTRL write edge); CTRL reads 0x4.
REQ-026 Auto-reload: PRESCALE=0, RELOAD=5, COUNT=0, CTRL=0x3 -> expired set on the first tick; COUNT sequence 5,4,3,2,1,0,5 with period 6 cycles; en stays 1.
REQ-027 Collisions: write COUNT=0x100 on a tick edge -> COUNT reads 0x100 with no decrement; write STATUS=1 on an expiry edge -> expired reads 1.
REQ-028 Decode: write 0xDEADBEEF to BASE_ADDR+0x14 and to BASE_ADDR+0x20 -> no register changes; both addresses read 0. BASE_ADDR+0x0B reads RELOAD.
REQ-029 Reset mid-run: COUNT=10 with en=1, assert cpu_rst for 1 cycle -> all registers read 0, timer_irq=0, no tick for 20 cycles afterwards.

Source files
------------

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - memory-mapped prescaled countdown timer with level interrupt
//
// Purpose: a 32-byte register window (CTRL, PRESCALE, RELOAD, COUNT, STATUS)
// at BASE_ADDR. A prescaler divides cpu_clk by PRESCALE+1. Each prescaler
// tick decrements COUNT. When a tick finds COUNT at zero, the timer expires.
// It then either reloads COUNT (auto_reload) or stops by clearing en.
//
// Ports:
//   cpu_clk    in   1   clock, all state on rising edge
//   cpu_rst    in   1   synchronous active-high reset
//   Bus_addr   in  32   byte address (bits [1:0] ignored)
//   Bus_wen    in   1   write strobe, commits on the rising edge
//   Bus_wdata  in  32   write data
//   Bus_rdata  out 32   combinational read data, zero for misses/holes
//   timer_irq  out  1   STATUS.expired AND CTRL.irq_en

module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_F020
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic        timer_irq
);

    localparam logic [2:0] SEL_CTRL     = 3'd0;
    localparam logic [2:0] SEL_PRESCALE = 3'd1;
    localparam logic [2:0] SEL_RELOAD   = 3'd2;
    localparam logic [2:0] SEL_COUNT    = 3'd3;
    localparam logic [2:0] SEL_STATUS   = 3'd4;

    logic [2:0]  ctrl_q, ctrl_d;          // {irq_en, auto_reload, en}
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] reload_q, reload_d;
    logic [31:0] count_q, count_d;
    logic        expired_q, expired_d;
    logic [15:0] pcnt_q, pcnt_d;

    logic        hit;
    logic [2:0]  sel;
    logic        wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
    logic        en, auto_reload, tick, expire;
    logic        unused_addr_bits;

    assign hit = (Bus_addr[31:5] == BASE_ADDR[31:5]);
    assign sel = Bus_addr[4:2];
    assign unused_addr_bits = ^Bus_addr[1:0];

    assign wr_ctrl     = Bus_wen && hit && (sel == SEL_CTRL);
    assign wr_prescale = Bus_wen && hit && (sel == SEL_PRESCALE);
    assign wr_reload   = Bus_wen && hit && (sel == SEL_RELOAD);
    assign wr_count    = Bus_wen && hit && (sel == SEL_COUNT);
    assign wr_status   = Bus_wen && hit && (sel == SEL_STATUS);

    assign en          = ctrl_q[0];
    assign auto_reload = ctrl_q[1];

    // Equality compare only: if PRESCALE is lowered below pcnt, pcnt runs
    // on through 16'hFFFF and wraps before it can match again.
    assign tick   = en && (pcnt_q == prescale_q);
    assign expire = tick && (count_q == 32'd0);

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        count_d    = count_q;
        expired_d  = expired_q;
        pcnt_d     = pcnt_q;

        // Timer-side updates first; bus writes below override them.
        if (en) begin
            pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
        end
        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (auto_reload) begin
                count_d = reload_q;
            end else begin
                count_d = 32'd0;
            end
        end
        if (expire && !auto_reload) begin
            ctrl_d[0] = 1'b0;
        end

        // Write-one-to-clear, but a simultaneous expiry still sets the flag.
        if (wr_status && Bus_wdata[0]) begin
            expired_d = 1'b0;
        end
        if (expire) begin
            expired_d = 1'b1;
        end

        if (wr_ctrl) begin
            ctrl_d = Bus_wdata[2:0];
            // Restart the prescale period on a 0->1 enable.
            if (Bus_wdata[0] && !en) begin
                pcnt_d = 16'd0;
            end
        end
        if (wr_prescale) begin
            prescale_d = Bus_wdata[15:0];
        end
        if (wr_reload) begin
            reload_d = Bus_wdata;
        end
        if (wr_count) begin
            count_d = Bus_wdata;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            ctrl_q     <= 3'd0;
            prescale_q <= 16'd0;
            reload_q   <= 32'd0;
            count_q    <= 32'd0;
            expired_q  <= 1'b0;
            pcnt_q     <= 16'd0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            pcnt_q     <= pcnt_d;
        end
    end

    always_comb begin
        Bus_rdata = 32'd0;
        if (hit) begin
            case (sel)
                SEL_CTRL:     Bus_rdata = {29'd0, ctrl_q};
                SEL_PRESCALE: Bus_rdata = {16'd0, prescale_q};
                SEL_RELOAD:   Bus_rdata = reload_q;
                SEL_COUNT:    Bus_rdata = count_q;
                SEL_STATUS:   Bus_rdata = {31'd0, expired_q};
                default:      Bus_rdata = 32'd0;
            endcase
        end
    end

    assign timer_irq = expired_q && ctrl_q[2];

endmodule

// File: tb/tb_bus_timer.sv
// tb/tb_bus_timer.sv - self-checking bench for bus_timer

module tb_bus_timer;

    localparam logic [31:0] B        = 32'hFFFF_F020;
    localparam logic [31:0] A_CTRL   = B + 32'h00;
    localparam logic [31:0] A_PRE    = B + 32'h04;
    localparam logic [31:0] A_REL    = B + 32'h08;
    localparam logic [31:0] A_CNT    = B + 32'h0C;
    localparam logic [31:0] A_STAT   = B + 32'h10;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    bus_timer #(.BASE_ADDR(B)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .Bus_addr  (Bus_addr),
        .Bus_wen   (Bus_wen),
        .Bus_wdata (Bus_wdata),
        .Bus_rdata (Bus_rdata),
        .timer_irq (timer_irq)
    );

    always #10 cpu_clk = ~cpu_clk;

    // Reference model: register file plus prescaler phase, advanced once per
    // rising edge from the bus inputs as seen just before that edge.
    logic [2:0]  m_ctrl;
    logic [15:0] m_pre;
    logic [31:0] m_rel;
    logic [31:0] m_cnt;
    logic        m_exp;
    logic [15:0] m_phase;

    always @(posedge cpu_clk) begin : model
        logic        tick_now, fire, hitw;
        logic [4:0]  off;
        logic [2:0]  n_ctrl;
        logic [15:0] n_pre, n_phase;
        logic [31:0] n_rel, n_cnt;
        logic        n_exp;
        if (cpu_rst) begin
            m_ctrl <= 0; m_pre <= 0; m_rel <= 0; m_cnt <= 0; m_exp <= 0; m_phase <= 0;
        end else begin
            n_ctrl = m_ctrl; n_pre = m_pre; n_rel = m_rel;
            n_cnt = m_cnt; n_exp = m_exp; n_phase = m_phase;
            tick_now = m_ctrl[0] && (m_phase == m_pre);
            fire = tick_now && (m_cnt == 0);
            if (m_ctrl[0]) n_phase = tick_now ? 16'd0 : 16'(m_phase + 1);
            if (tick_now) n_cnt = (m_cnt == 0) ? (m_ctrl[1] ? m_rel : 32'd0) : m_cnt - 1;
            if (fire && !m_ctrl[1]) n_ctrl[0] = 1'b0;
            hitw = Bus_wen && (Bus_addr[31:5] == B[31:5]);
            off = {Bus_addr[4:2], 2'b00};
            if (hitw && off == 5'h10 && Bus_wdata[0]) n_exp = 1'b0;
            if (fire) n_exp = 1'b1;
            if (hitw && off == 5'h00) begin
                if (Bus_wdata[0] && !m_ctrl[0]) n_phase = 0;
                n_ctrl = Bus_wdata[2:0];
            end
            if (hitw && off == 5'h04) n_pre = Bus_wdata[15:0];
            if (hitw && off == 5'h08) n_rel = Bus_wdata;
            if (hitw && off == 5'h0C) n_cnt = Bus_wdata;
            m_ctrl <= n_ctrl; m_pre <= n_pre; m_rel <= n_rel;
            m_cnt <= n_cnt; m_exp <= n_exp; m_phase <= n_phase;
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:5] != B[31:5]) return 32'd0;
        case (a[4:2])
            3'd0: return {29'd0, m_ctrl};
            3'd1: return {16'd0, m_pre};
            3'd2: return m_rel;
            3'd3: return m_cnt;
            3'd4: return {31'd0, m_exp};
            default: return 32'd0;
        endcase
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge cpu_clk);
        Bus_addr = a; Bus_wdata = d; Bus_wen = 1'b1;
        @(posedge cpu_clk);
        #1 Bus_wen = 1'b0;
    endtask

    // Combinational read within the current low phase; consumes no edge.
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        Bus_wen = 1'b0; Bus_addr = a;
        #1 d = Bus_rdata;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    task automatic do_reset();
        @(negedge cpu_clk);
        cpu_rst = 1'b1; Bus_wen = 1'b0;
        @(posedge cpu_clk);
        #1 cpu_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        @(negedge cpu_clk);
        for (int i = 0; i < 8; i++) begin
            peek(B + 32'(i * 4), d);
            checks++;
            if (d !== 32'd0) begin
                errors++; $display("FAIL reset_read off=%0h got=%h exp=0", i * 4, d);
            end
        end
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq got=%b exp=0", timer_irq);
        end
    endtask

    task automatic test_basic_countdown();
        logic [31:0] d;
        do_reset();
        bus_write(A_PRE, 3);
        bus_write(A_CNT, 2);
        bus_write(A_CTRL, 32'h5);
        wait_edges(4);
        peek(A_CNT, d); checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL basic_cnt_tick1 got=%0d exp=1", d); end
        wait_edges(4);
        peek(A_CNT, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL basic_cnt_tick2 got=%0d exp=0", d); end
        wait_edges(3);
        peek(A_STAT, d); checks++;
        if (d !== 32'd0 || timer_irq !== 1'b0) begin
            errors++; $display("FAIL basic_early_expiry status=%0d irq=%b exp=0/0", d, timer_irq);
        end
        wait_edges(1);
        peek(A_STAT, d); checks++;
        if (d !== 32'd1 || timer_irq !== 1'b1) begin
            errors++; $display("FAIL basic_expiry status=%0d irq=%b exp=1/1", d, timer_irq);
        end
        peek(A_CTRL, d); checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL basic_ctrl got=%h exp=4", d); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        logic [31:0] seq [7] = '{5, 4, 3, 2, 1, 0, 5};
        do_reset();
        bus_write(A_PRE, 0);
        bus_write(A_REL, 5);
        bus_write(A_CNT, 0);
        bus_write(A_CTRL, 32'h3);
        for (int i = 0; i < 7; i++) begin
            wait_edges(1);
            peek(A_CNT, d); checks++;
            if (d !== seq[i]) begin
                errors++; $display("FAIL reload_seq step=%0d got=%0d exp=%0d", i, d, seq[i]);
            end
            if (i == 0) begin
                peek(A_STAT, d); checks++;
                if (d !== 32'd1) begin errors++; $display("FAIL reload_expired got=%0d exp=1", d); end
            end
        end
        peek(A_CTRL, d); checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL reload_ctrl got=%h exp=3", d); end
    endtask

    task automatic test_collisions();
        logic [31:0] d;
        do_reset();
        bus_write(A_PRE, 3);
        bus_write(A_CNT, 50);
        bus_write(A_CTRL, 32'h1);
        repeat (3) @(posedge cpu_clk);
        bus_write(A_CNT, 32'h100);
        @(negedge cpu_clk);
        peek(A_CNT, d); checks++;
        if (d !== 32'h100) begin errors++; $display("FAIL coll_count_write got=%h exp=100", d); end
        wait_edges(4);
        peek(A_CNT, d); checks++;
        if (d !== 32'hFF) begin errors++; $display("FAIL coll_next_tick got=%h exp=ff", d); end

        do_reset();
        bus_write(A_PRE, 0);
        bus_write(A_CNT, 0);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_STAT, 32'h1);
        @(negedge cpu_clk);
        peek(A_STAT, d); checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL coll_status_set_wins got=%0d exp=1", d); end
        peek(A_CTRL, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL coll_autoclear got=%h exp=0", d); end

        do_reset();
        bus_write(A_PRE, 0);
        bus_write(A_CNT, 0);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_CTRL, 32'h5);
        @(negedge cpu_clk);
        peek(A_CTRL, d); checks++;
        if (d !== 32'h5 || timer_irq !== 1'b1) begin
            errors++; $display("FAIL coll_ctrl_write ctrl=%h irq=%b exp=5/1", d, timer_irq);
        end
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STAT, 32'h1);
        @(negedge cpu_clk);
        peek(A_STAT, d); checks++;
        if (d !== 32'd0 || timer_irq !== 1'b0) begin
            errors++; $display("FAIL status_clear status=%0d irq=%b exp=0/0", d, timer_irq);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        do_reset();
        bus_write(A_REL, 32'h1234_5678);
        bus_write(A_PRE, 32'hFFFF_0077);
        bus_write(A_CNT, 32'h42);
        bus_write(B + 32'h14, 32'hDEAD_BEEF);
        bus_write(B + 32'h20, 32'hDEAD_BEEF);
        @(negedge cpu_clk);
        peek(B + 32'h14, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL decode_hole got=%h exp=0", d); end
        peek(B + 32'h20, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL decode_miss got=%h exp=0", d); end
        peek(B + 32'h0B, d); checks++;
        if (d !== 32'h1234_5678) begin errors++; $display("FAIL decode_byteaddr got=%h exp=12345678", d); end
        peek(A_PRE, d); checks++;
        if (d !== 32'h77) begin errors++; $display("FAIL decode_prescale got=%h exp=77", d); end
        peek(A_CNT, d); checks++;
        if (d !== 32'h42) begin errors++; $display("FAIL decode_count got=%h exp=42", d); end
        peek(A_CTRL, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL decode_ctrl got=%h exp=0", d); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        do_reset();
        bus_write(A_PRE, 0);
        bus_write(A_CNT, 10);
        bus_write(A_CTRL, 32'h5);
        wait_edges(3);
        cpu_rst = 1'b1; Bus_addr = A_CNT; Bus_wdata = 32'd7; Bus_wen = 1'b1;
        @(posedge cpu_clk);
        #1 cpu_rst = 1'b0; Bus_wen = 1'b0;
        @(negedge cpu_clk);
        for (int i = 0; i < 5; i++) begin
            peek(B + 32'(i * 4), d); checks++;
            if (d !== 32'd0) begin
                errors++; $display("FAIL midrun_reset off=%0h got=%h exp=0", i * 4, d);
            end
        end
        for (int i = 0; i < 20; i++) begin
            wait_edges(1);
            peek(A_CNT, d); checks++;
            if (d !== 32'd0 || timer_irq !== 1'b0 || model_read(A_STAT) !== 32'd0) begin
                errors++; $display("FAIL midrun_quiet cyc=%0d cnt=%0d irq=%b exp=0/0", i, d, timer_irq);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp_d;
        int sel;
        do_reset();
        for (int it = 0; it < 3000; it++) begin
            @(negedge cpu_clk);
            cpu_rst = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                cpu_rst = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                sel = $urandom_range(0, 7);
                a = B + 32'(sel * 4) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) a = a + 32'h20;
                case (sel)
                    0: d = $urandom;
                    1: d = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 4));
                    2, 3: d = 32'($urandom_range(0, 6));
                    default: d = $urandom;
                endcase
                Bus_addr = a; Bus_wdata = d; Bus_wen = 1'b1;
            end else begin
                a = B + 32'($urandom_range(0, 31));
                peek(a, d);
                exp_d = model_read(a);
                checks++;
                if (d !== exp_d || timer_irq !== (m_exp & m_ctrl[2])) begin
                    errors++;
                    $display("FAIL random_read it=%0d addr=%h got=%h irq=%b exp=%h irq=%b",
                             it, a, d, timer_irq, exp_d, m_exp & m_ctrl[2]);
                end
            end
        end
        @(negedge cpu_clk);
        cpu_rst = 1'b0; Bus_wen = 1'b0;
    endtask

    initial begin
        cpu_rst = 1'b1; Bus_addr = 32'd0; Bus_wen = 1'b0; Bus_wdata = 32'd0;
        repeat (2) @(posedge cpu_clk);
        test_reset();
        test_basic_countdown();
        test_auto_reload();
        test_collisions();
        test_decode();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
